ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

PS/2 device-to-host receiver for the keyboard path: synchronises and deglitches the raw PS/2 clock/data lines, deserialises 11-bit frames, checks start/parity/stop, and buffers good scan codes in a small FIFO. It sits directly upstream of the ZX keyboard-matrix decoder. It presents one byte at a time through a ready/read handshake: a one-cycle read strobe latches the head byte onto a held output register.

## Interface
- FIFO_DEPTH, 8, scan-code FIFO entries (power of two, ≥2)
- FILTER_LEN, 8, consecutive stable clk cycles before a filtered PS/2 line changes
- TIMEOUT_CYCLES, 28000, idle clk cycles inside a frame before abort (2 ms at 14 MHz)
- clk  in  1  system clock (14 MHz); the only clock
- reset  in  1  synchronous, active-high reset
- ps2_clk_i  in  1  raw PS/2 clock line, asynchronous
- ps2_data_i  in  1  raw PS/2 data line, asynchronous
- rx_read  in  1  one-cycle pop strobe from the consumer
- rx_scan_code  out  8  last popped byte, held until the next accepted pop
- rx_data_ready  out  1  FIFO non-empty
- rx_error  out  1  one-cycle pulse on a discarded frame (parity, stop, or timeout)
- rx_overflow  out  1  sticky; a good byte was dropped because the FIFO was full

## Operation
- Line conditioning:
  - Each line passes through a 2-FF synchroniser, then a filter.
  - The filtered value takes the synchronised value only after FILTER_LEN consecutive equal samples.
  - Filter state resets to 1 (bus idle).
- Bit sampling:
  - A filtered clock 1→0 transition gives a one-cycle `fall` strobe.
  - On `fall`, the filtered data value is the sampled bit.
- Frame FSM (encoding in package), acting on `fall` only:
  - IDLE: bit 0 → DATA, bit_cnt=0. Bit 1 → stay IDLE; no error (noise).
  - DATA: shift bit into sr[7] and shift right (LSB first). At bit_cnt=7 → PARITY; otherwise bit_cnt+1.
  - PARITY: store bit → STOP.
  - STOP:
    - Good frame: stop bit =1 and XOR(sr, parity) =1 (odd parity). Push sr → IDLE.
    - Bad frame: otherwise pulse rx_error, discard → IDLE.
- Timeout:
  - Counter clears on every `fall` and in IDLE; it increments in any other state.
  - On reaching TIMEOUT_CYCLES-1: → IDLE, partial frame discarded, rx_error pulses.
- FIFO (write ptr, read ptr, count with width clog2(FIFO_DEPTH)+1):
  - Push when count==FIFO_DEPTH: byte dropped, rx_overflow←1, no rx_error.
  - rx_read with count>0: rx_scan_code←mem[rd], rd+1 (wraps modulo FIFO_DEPTH), count−1.
  - rx_read with count==0: ignored; rx_scan_code unchanged.
  - Push and pop in the same cycle: both performed, count unchanged. This holds when full (pop frees the slot, no overflow) and when empty-then-push (pop ignored, count becomes 1).
- rx_data_ready = (count≠0), driven combinationally from the registered count.
- Reset values: rx_scan_code=8'h00, rx_data_ready=0, rx_error=0, rx_overflow=0. FIFO is empty, FSM is in IDLE, counters are 0.
- Reset mid-frame aborts silently; the partial byte is lost.

## Timing
- Input to filtered line: 2 sync cycles plus FILTER_LEN cycles. `fall` asserts the cycle after the filtered clock goes low.
- Push: count is updated on the clk edge ending the `fall` cycle of the stop bit. rx_data_ready is high the following cycle.
- Pop latency:
  - rx_read sampled high at edge N makes rx_scan_code valid from cycle N+1.
  - rx_data_ready reflects the post-pop count from cycle N+1.
  - rx_scan_code stays stable until the next accepted pop. This lets the consumer strobe rx_read, then inspect the byte over several later cycles.
- rx_error is exactly one cycle wide. At most one error per frame.
- Throughput: one byte per ~1 ms PS/2 frame, so FIFO_DEPTH 8 covers multi-byte sequences (E0 F0 xx, Pause).

## Structure
- Package ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8)
  - scan-code byte typedef
  - shared prefix constants 8'hE0 and 8'hF0 for downstream use
- One sub-module, ps2_sync_filter: synchroniser plus FILTER_LEN filter for a single line, instantiated twice.
- FSM, timeout counter and FIFO stay in the top module.

## Test plan
- Frame for 8'h1C (start 0, data LSB first, parity 0, stop 1, 12.5 kHz) → rx_data_ready rises. rx_read pulse → rx_scan_code=8'h1C next cycle, rx_data_ready=0.
- Frames 8'hE0, 8'hF0, 8'h75 with no reads, then three reads spaced 3 cycles → codes returned in order. Each code is held between pops. rx_data_ready falls after the third read.
- Frame 8'h29 with parity bit flipped → one-cycle rx_error, rx_data_ready stays 0. Repeat with stop=0 → same result.
- 9 good frames with no reads (depth 8) → rx_overflow=1, count 8, first 8 codes intact. A push coincident with rx_read while full → accepted, no overflow change.
- Abort after 4 data bits; clock held high >TIMEOUT_CYCLES → rx_error pulse. A following 8'h5A frame is received correctly.
- 3-cycle low glitches on ps2_clk_i mid-frame → no extra bits, byte correct. Reset asserted mid-frame → all outputs 0, next frame decodes cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, frame constants,
// the scan-code byte type and the prefix codes the matrix decoder looks for.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef logic [DATA_BITS-1:0] scan_code_t;

  localparam scan_code_t PREFIX_EXT   = 8'hE0;
  localparam scan_code_t PREFIX_BREAK = 8'hF0;

  // A frame is good when the data byte and its parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input scan_code_t data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings one raw PS/2 line into the clk domain and rejects short glitches:
// the filtered output only follows the synchronised line once the new level
// has been seen for FILTER_LEN consecutive cycles. Idles high like the bus.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser for the asynchronous line
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], line_i};
  end

  // Count consecutive samples that disagree with the filtered level; flip once enough agree
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync_q[1];
      else                              cnt_d  = cnt_q + 1'b1;
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: conditions both lines, deserialises 11-bit
// frames on falling PS/2 clock edges, validates start/parity/stop, aborts
// stalled frames, and queues good scan codes for the keyboard-matrix decoder.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 28000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       rx_read,
  output logic [7:0] rx_scan_code,
  output logic       rx_data_ready,
  output logic       rx_error,
  output logic       rx_overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam int BCW = $clog2(DATA_BITS);

  logic clk_filt, data_filt, clk_prev_q, fall;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .reset(reset), .line_i(ps2_clk_i), .line_o(clk_filt)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .reset(reset), .line_i(ps2_data_i), .line_o(data_filt)
  );

  // Remember the previous filtered clock so a 1->0 step gives a single-cycle strobe
  always_ff @(posedge clk) begin
    if (reset) clk_prev_q <= 1'b1;
    else       clk_prev_q <= clk_filt;
  end

  assign fall = clk_prev_q & ~clk_filt;

  ps2_state_e     state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  scan_code_t     sr_q, sr_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           err_q, err_d;
  logic           push;

  // Frame FSM and inactivity timeout; a stalled frame is dropped with an error pulse
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    push      = 1'b0;
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (data_filt == START_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          sr_d = {data_filt, sr_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) state_d   = PARITY;
          else                                  bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: begin
          par_d   = data_filt;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_filt == STOP_BIT && odd_parity_ok(sr_q, par_q)) push  = 1'b1;
          else                                                      err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = '0;
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Frame FSM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  scan_code_t  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  scan_code_t    scan_q;
  logic          ovf_q;
  logic          do_pop, do_push;

  // A pop while full frees the slot for a simultaneous push; a pop on empty is ignored
  always_comb begin
    do_pop  = rx_read && (count_q != '0);
    do_push = push && ((count_q != (AW+1)'(FIFO_DEPTH)) || do_pop);
  end

  // Scan-code storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= sr_q;
  end

  // FIFO pointers, occupancy, held output byte and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      scan_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        scan_q <= mem_q[rd_q];
      end
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

  assign rx_scan_code  = scan_q;
  assign rx_data_ready = (count_q != '0);
  assign rx_error      = err_q;
  assign rx_overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo. A fast PS/2 clock and a short
// timeout keep the run short; expected bytes come from a queue model of
// the scan-code buffer fed by what each transmitted frame should produce.
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 8;
  localparam int FILT    = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_scan_code;
  logic       rx_data_ready;
  logic       rx_error;
  logic       rx_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int exp_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_code = 8'h00;
  logic       exp_ovf = 1'b0;

  ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .rx_read(rx_read), .rx_scan_code(rx_scan_code), .rx_data_ready(rx_data_ready),
    .rx_error(rx_error), .rx_overflow(rx_overflow)
  );

  // 100 MHz-style simulation clock; the period only sets the time scale
  always #5 clk = ~clk;

  // Count every cycle rx_error is high, so a stretched pulse shows up as an extra error
  always @(negedge clk) begin
    if (rx_error === 1'b1) err_seen++;
  end

  // Hard stop if something stalls the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Model of the buffer: a good byte is queued unless the buffer already holds DEPTH bytes
  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      exp_ovf = 1'b1;
  endtask

  // Model of an accepted read: the head byte becomes the held output
  task automatic model_pop();
    if (exp_q.size() > 0) exp_code = exp_q.pop_front();
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_code = 8'h00;
    exp_ovf  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read();
    @(negedge clk); rx_read = 1'b1;
    @(negedge clk); rx_read = 1'b0;
  endtask

  // Drive one 11-bit frame; optional corruption, a 3-cycle clock glitch in each high phase,
  // and a read strobe placed on the very cycle the stop bit is taken
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit coincide, input bit glitch);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); ps2_data_i = bits[i];
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (glitch && k == 6) ps2_clk_i = 1'b0;
        if (glitch && k == 9) ps2_clk_i = 1'b1;
      end
      ps2_clk_i = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (coincide && i == 10 && k == 10) rx_read = 1'b1;
        if (coincide && i == 10 && k == 11) rx_read = 1'b0;
      end
      ps2_clk_i = 1'b1;
    end
    @(negedge clk); ps2_data_i = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  // Start bit plus the first n data bits, then the bus is left idle
  task automatic send_partial(input logic [7:0] b, input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk); ps2_data_i = (i == 0) ? 1'b0 : b[i-1];
      repeat (HALF) @(negedge clk);
      ps2_clk_i = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk_i = 1'b1;
    end
    @(negedge clk); ps2_data_i = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (rx_scan_code !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_code: got %h want 00", rx_scan_code); end
    n_cmp++; if (rx_data_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 0", rx_data_ready); end
    n_cmp++; if (rx_error !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_error: got %b want 0", rx_error); end
    n_cmp++; if (rx_overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overflow: got %b want 0", rx_overflow); end
  endtask

  task automatic test_single();
    send_frame(8'h1C, 0, 0, 0, 0); model_push(8'h1C);
    n_cmp++; if (rx_data_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL single_ready: got %b want 1", rx_data_ready); end
    do_read(); model_pop();
    n_cmp++; if (rx_scan_code !== 8'h1C) begin n_bad++; $display("[TB] FAIL single_code: got %h want 1c", rx_scan_code); end
    n_cmp++; if (rx_data_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL single_ready_after: got %b want 0", rx_data_ready); end
  endtask

  task automatic test_sequence();
    logic [7:0] codes [3];
    codes = '{8'hE0, 8'hF0, 8'h75};
    for (int i = 0; i < 3; i++) begin
      send_frame(codes[i], 0, 0, 0, 0); model_push(codes[i]);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(); model_pop();
      for (int c = 0; c < 3; c++) begin
        n_cmp++; if (rx_scan_code !== exp_code) begin n_bad++; $display("[TB] FAIL seq_hold[%0d.%0d]: got %h want %h", i, c, rx_scan_code, exp_code); end
        @(negedge clk);
      end
      n_cmp++; if (rx_data_ready !== (exp_q.size() != 0)) begin n_bad++; $display("[TB] FAIL seq_ready[%0d]: got %b want %b", i, rx_data_ready, exp_q.size() != 0); end
    end
  endtask

  task automatic test_errors();
    send_frame(8'h29, 1, 0, 0, 0); exp_err++;
    n_cmp++; if (err_seen !== exp_err) begin n_bad++; $display("[TB] FAIL parity_error_count: got %0d want %0d", err_seen, exp_err); end
    n_cmp++; if (rx_data_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL parity_ready: got %b want 0", rx_data_ready); end
    send_frame(8'h29, 0, 1, 0, 0); exp_err++;
    n_cmp++; if (err_seen !== exp_err) begin n_bad++; $display("[TB] FAIL stop_error_count: got %0d want %0d", err_seen, exp_err); end
    n_cmp++; if (rx_data_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL stop_ready: got %b want 0", rx_data_ready); end
    do_read(); model_pop();
    n_cmp++; if (rx_scan_code !== exp_code) begin n_bad++; $display("[TB] FAIL empty_read_code: got %h want %h", rx_scan_code, exp_code); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_frame(b, 0, 0, 0, 0); model_push(b);
    end
    n_cmp++; if (rx_overflow !== exp_ovf) begin n_bad++; $display("[TB] FAIL ovf_flag: got %b want %b", rx_overflow, exp_ovf); end
    n_cmp++; if (err_seen !== exp_err) begin n_bad++; $display("[TB] FAIL ovf_no_error: got %0d want %0d", err_seen, exp_err); end
    b = 8'($urandom);
    send_frame(b, 0, 0, 1, 0); model_pop(); model_push(b);
    n_cmp++; if (rx_scan_code !== exp_code) begin n_bad++; $display("[TB] FAIL coincide_code: got %h want %h", rx_scan_code, exp_code); end
    for (int i = 0; i < DEPTH; i++) begin
      do_read(); model_pop();
      n_cmp++; if (rx_scan_code !== exp_code) begin n_bad++; $display("[TB] FAIL drain[%0d]: got %h want %h", i, rx_scan_code, exp_code); end
    end
    n_cmp++; if (rx_data_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL drain_ready: got %b want 0", rx_data_ready); end
    n_cmp++; if (rx_overflow !== exp_ovf) begin n_bad++; $display("[TB] FAIL ovf_sticky: got %b want %b", rx_overflow, exp_ovf); end
    apply_reset();
  endtask

  task automatic test_timeout();
    send_partial(8'hA5, 4);
    repeat (TIMEOUT + 60) @(negedge clk);
    exp_err++;
    n_cmp++; if (err_seen !== exp_err) begin n_bad++; $display("[TB] FAIL timeout_error_count: got %0d want %0d", err_seen, exp_err); end
    n_cmp++; if (rx_data_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL timeout_ready: got %b want 0", rx_data_ready); end
    send_frame(8'h5A, 0, 0, 0, 0); model_push(8'h5A);
    do_read(); model_pop();
    n_cmp++; if (rx_scan_code !== 8'h5A) begin n_bad++; $display("[TB] FAIL after_timeout_code: got %h want 5a", rx_scan_code); end
  endtask

  task automatic test_glitch();
    send_frame(8'h3B, 0, 0, 0, 1); model_push(8'h3B);
    do_read(); model_pop();
    n_cmp++; if (rx_scan_code !== 8'h3B) begin n_bad++; $display("[TB] FAIL glitch_code: got %h want 3b", rx_scan_code); end
    n_cmp++; if (err_seen !== exp_err) begin n_bad++; $display("[TB] FAIL glitch_no_error: got %0d want %0d", err_seen, exp_err); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h44, 0, 0, 0, 0); model_push(8'h44);
    do_read(); model_pop();
    send_frame(8'h4D, 0, 0, 0, 0); model_push(8'h4D);
    send_partial(8'h66, 3);
    apply_reset();
    n_cmp++; if (rx_scan_code !== 8'h00) begin n_bad++; $display("[TB] FAIL midreset_code: got %h want 00", rx_scan_code); end
    n_cmp++; if (rx_data_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_ready: got %b want 0", rx_data_ready); end
    n_cmp++; if (rx_overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_overflow: got %b want 0", rx_overflow); end
    send_frame(8'h16, 0, 0, 0, 0); model_push(8'h16);
    do_read(); model_pop();
    n_cmp++; if (rx_scan_code !== 8'h16) begin n_bad++; $display("[TB] FAIL after_reset_code: got %h want 16", rx_scan_code); end
    n_cmp++; if (err_seen !== exp_err) begin n_bad++; $display("[TB] FAIL midreset_no_error: got %0d want %0d", err_seen, exp_err); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bad;
    int nrd;
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, bad, 0, 0, 0);
      if (bad) exp_err++;
      else     model_push(b);
      n_cmp++; if (err_seen !== exp_err) begin n_bad++; $display("[TB] FAIL rand_error[%0d]: got %0d want %0d", i, err_seen, exp_err); end
      n_cmp++; if (rx_data_ready !== (exp_q.size() != 0)) begin n_bad++; $display("[TB] FAIL rand_ready[%0d]: got %b want %b", i, rx_data_ready, exp_q.size() != 0); end
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) begin
        do_read(); model_pop();
        n_cmp++; if (rx_scan_code !== exp_code) begin n_bad++; $display("[TB] FAIL rand_code[%0d.%0d]: got %h want %h", i, r, rx_scan_code, exp_code); end
      end
    end
    n_cmp++; if (rx_overflow !== exp_ovf) begin n_bad++; $display("[TB] FAIL rand_overflow: got %b want %b", rx_overflow, exp_ovf); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_errors();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
